// File: rtl/comparer_sync.sv
// Streaming byte-sequence matcher: flags the cycle in which the last L loaded
// characters, including the one currently presented, equal the reference string.
module comparer_sync #(
    parameter int             L   = 3,
    parameter logic [8*L-1:0] Ref = "ABC"
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       load,
    input  logic [7:0] data,
    output logic       resolve,
    output logic       reject
);

    logic match;

    generate
        if (L == 1) begin : g_single
            assign match = (data == Ref[7:0]);
        end else begin : g_multi
            localparam int CW = $clog2(L);
            localparam logic [CW-1:0] CNT_FULL = CW'(L - 1);

            // Byte 0 is the newest character; the oldest sits in the top byte,
            // which lines up with the reference layout.
            logic [8*(L-1)-1:0] hist_q, hist_d, hist_shift;
            logic [CW-1:0]      cnt_q, cnt_d;

            assign hist_shift[7:0] = data;
            for (genvar gi = 1; gi < L - 1; gi++) begin : g_shift
                assign hist_shift[8*gi +: 8] = hist_q[8*(gi-1) +: 8];
            end

            always_comb begin
                hist_d = hist_q;
                cnt_d  = cnt_q;
                if (load) begin
                    hist_d = hist_shift;
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge restart) begin
                if (!restart) begin
                    hist_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    hist_q <= hist_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign match = (cnt_q == CNT_FULL) &&
                           (hist_q == Ref[8*L-1:8]) &&
                           (data == Ref[7:0]);
        end
    endgenerate

    assign resolve = restart & load & match;
    assign reject  = restart & load & ~match;

endmodule

// File: tb/tb_comparer_sync.sv
// Self-checking bench for comparer_sync: table-driven vectors for Ref="ABC",
// hand-written sequences for an async reset pulse and an L=1 instance.
module tb_comparer_sync;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] d;
        logic       res;
        logic       rej;
    } vec_t;

    logic       clk = 1'b0;
    logic       restart = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = 8'h00;
    logic       resolve, reject;

    logic       load1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       resolve1, reject1;

    int compared = 0;
    int mismatched = 0;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    comparer_sync #(.L(3), .Ref("ABC")) dut (
        .clock   (clk),
        .restart (restart),
        .load    (load),
        .data    (data),
        .resolve (resolve),
        .reject  (reject)
    );

    comparer_sync #(.L(1), .Ref("Z")) dut1 (
        .clock   (clk),
        .restart (restart),
        .load    (load1),
        .data    (data1),
        .resolve (resolve1),
        .reject  (reject1)
    );

    task automatic add(input logic r, input logic l, input logic [7:0] d,
                       input logic res, input logic rej);
        vec_t v;
        v.rst = r; v.ld = l; v.d = d; v.res = res; v.rej = rej;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [1:0] act);
        logic [1:0] e;
        e = exp_q.pop_front();
        compared++;
        if (act !== e) begin
            mismatched++;
            $display("FAIL %s: {resolve,reject} got %b expected %b", name, act, e);
        end else begin
            $display("ok   %s: {resolve,reject} = %b", name, act);
        end
    endtask

    // Drive one cycle on the L=3 instance and check its outputs before the edge.
    task automatic step(input string name, input logic r, input logic l,
                        input logic [7:0] d, input logic res, input logic rej);
        @(negedge clk);
        restart = r;
        load    = l;
        data    = d;
        exp_q.push_back({res, rej});
        #2;
        compare($sformatf("%s data=%c rst=%b ld=%b", name, d, r, l), {resolve, reject});
    endtask

    task automatic step1(input string name, input logic r, input logic l,
                         input logic [7:0] d, input logic res, input logic rej);
        @(negedge clk);
        restart = r;
        load1   = l;
        data1   = d;
        exp_q.push_back({res, rej});
        #2;
        compare($sformatf("%s data=%c rst=%b ld=%b", name, d, r, l), {resolve1, reject1});
    endtask

    initial begin
        // Reset then stream
        add(0, 0, "O", 0, 0);
        add(0, 1, "C", 0, 0);
        add(1, 0, "O", 0, 0);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        add(1, 1, "D", 0, 1);
        // Gapped load
        add(1, 1, "A", 0, 1);
        add(1, 0, "a", 0, 0);
        add(1, 1, "B", 0, 1);
        add(1, 0, "b", 0, 0);
        add(1, 1, "C", 1, 0);
        // Mismatch recovery and overlap: hits on bytes 7, 10, 17
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "X", 0, 1);
        add(1, 1, "C", 0, 1);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        // Reset mid-stream
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(0, 0, "C", 0, 0);
        add(1, 1, "C", 0, 1);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        // Held byte
        add(1, 1, "A", 0, 1);
        add(1, 1, "A", 0, 1);
        add(1, 1, "B", 0, 1);
        add(1, 1, "C", 1, 0);
        add(1, 0, "C", 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ld, vecs[i].d,
                 vecs[i].res, vecs[i].rej);
        end

        // Asynchronous reset pulse between edges wipes the partial A,B
        step("async_pre", 1, 1, "A", 0, 1);
        step("async_pre", 1, 1, "B", 0, 1);
        @(posedge clk);
        #1 restart = 1'b0;
        #1 restart = 1'b1;
        step("async_post", 1, 1, "C", 0, 1);
        step("async_refill", 1, 1, "A", 0, 1);
        step("async_refill", 1, 1, "B", 0, 1);
        step("async_refill", 1, 1, "C", 1, 0);
        load = 1'b0;

        // L=1 instance, Ref="Z"
        step1("l1_reset", 0, 1, "Z", 0, 0);
        step1("l1_first", 1, 1, "Z", 1, 0);
        step1("l1_miss", 1, 1, "Y", 0, 1);
        step1("l1_idle", 1, 0, "Z", 0, 0);
        step1("l1_again", 1, 1, "Z", 1, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
